ata_pio_arbiter: RTL and testbench
==================================

Name: ata_pio_arbiter

Overview:
- Shares the single ATA PIO register port (16-bit data, 3-bit address, CS0/CS1, IORD/IOWR) between two requesters. Requester 0 is the boot sequencer; requester 1 is the CPU I/O window.
- Runs one complete PIO register cycle per grant (setup, strobe, hold) using programmable cycle counts, then returns read data and a one-cycle acknowledge to the winner.
- Sits between the requesters and the ATA pins, and is the only driver of ata_cs_n, ata_adr, ata_iord_n, ata_iowr_n and ata_data.

Parameters:
- T_SETUP, 1, clk cycles that address/CS are valid before the strobe (1..15; 0 is treated as 1).
- T_STROBE, 2, clk cycles that IORD/IOWR is held low (1..15; 0 is treated as 1).
- T_HOLD, 1, clk cycles after the strobe rises that address/CS/write data stay valid (1..15; 0 is treated as 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  transaction request; held high until the matching ack
- we0 / we1  in  1  1 = register write, 0 = register read
- cs1sel0 / cs1sel1  in  1  1 = CS1 block (alt status), 0 = CS0 block
- adr0 / adr1  in  3  ATA register address
- wdata0 / wdata1  in  16  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  16  read data; valid while ack is high, held until the next read completes
- busy  out  1  high in every state except IDLE
- ata_cs_n  out  2  {CS1_n, CS0_n}
- ata_adr  out  3  register address
- ata_iord_n / ata_iowr_n  out  1  read/write strobes
- ata_data  inout  16  driven only during write transactions

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, ata_cs_n=2'b11, ata_adr=0, ata_iord_n=1, ata_iowr_n=1, ata_data=Z, ack0=ack1=0, rdata=0, busy=0, last_grant=1.
- States and transitions:
  - IDLE: if any req is high, latch the winner's we/cs1sel/adr/wdata, record grant, and go to SETUP.
  - SETUP: drive ata_adr and the selected cs_n low; stay T_SETUP cycles, then go to STROBE.
  - STROBE: assert ata_iord_n (read) or ata_iowr_n (write) low for T_STROBE cycles. On the final STROBE cycle's edge, capture ata_data into rdata (reads only). Then go to HOLD.
  - HOLD: strobe is high; cs/adr/write data stay unchanged for T_HOLD cycles; then go to DONE.
  - DONE: cs_n=2'b11; ack of the granted requester=1 for exactly this cycle; next state is IDLE.
- Write data: ata_data is driven from the first SETUP cycle through the last HOLD cycle; it is Z at all other times.
- Latency: if req is sampled in IDLE cycle n, ack is high in cycle n+T_SETUP+T_STROBE+T_HOLD+1. With defaults this is n+5.
- Turnaround: at least one IDLE cycle separates transactions.
- Requesters drop req on the edge where they see ack high. req still high in the following IDLE cycle counts as a new request.
- Changing a requester's req/adr/wdata after grant has no effect on the transaction in flight. Dropping req mid-transaction does not abort it; ack is still pulsed.
- Simultaneous req0 and req1 in IDLE: resolved per the Optional Feature. The loser stays pending and is granted in the next IDLE cycle in which it still requests.
- Reset mid-transaction: on the next edge all strobes/cs return to their reset values, ata_data goes Z, no ack is issued, and the grant is discarded.
- Phase counter: 4 bits, loaded with (T_x==0 ? 1 : T_x) - 1 on phase entry and decremented to 0.

Optional Feature:
- Macro ATA_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant goes to the requester not granted last (last_grant updates at each grant). last_grant=1 after reset, so req0 wins the first tie.
- Undefined: fixed priority; req0 always wins ties and last_grant is unused.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset, then req0 read, adr0=7, cs1sel0=0, pins return 16'h0050 → cs_n=2'b10 from cycle 1, iord_n low in cycles 2-3, ack0 in cycle 5, rdata=16'h0050, ata_data never driven.
- req1 write, adr1=6, wdata1=16'h00E0 → iowr_n low 2 cycles, ata_data=16'h00E0 from SETUP through HOLD then Z, ack1 pulses exactly once.
- req0 and req1 both held high continuously, 4 transactions → fixed build: first grant req0, and req1 is served only after req0 drops. RR build: grants alternate 0,1,0,1.
- T_SETUP=3, T_STROBE=4, T_HOLD=2, read → ack exactly 10 cycles after the IDLE sample, iord_n low exactly 4 cycles.
- Assert reset in the 2nd STROBE cycle of a write → next edge: iowr_n=1, cs_n=2'b11, ata_data=Z, no ack; a fresh req0 afterwards completes normally.
- cs1sel1=1 read, adr1=6 → ata_cs_n=2'b01 during SETUP..HOLD, CS0_n stays high.

Source files
------------

// File: rtl/ata_pio_arbiter.sv
// Two-requester arbiter for the ATA PIO register port. Each grant runs one setup/strobe/hold cycle.
// Tie-break is fixed (req0 wins) unless ATA_ARB_ROUND_ROBIN_EN is defined, which alternates from last_grant.
module ata_pio_arbiter #(
   parameter int T_SETUP  = 1,
   parameter int T_STROBE = 2,
   parameter int T_HOLD   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic        cs1sel0,
   input  logic        cs1sel1,
   input  logic [2:0]  adr0,
   input  logic [2:0]  adr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [15:0] rdata,
   output logic        busy,
   output logic [1:0]  ata_cs_n,
   output logic [2:0]  ata_adr,
   output logic        ata_iord_n,
   output logic        ata_iowr_n,
   inout  wire  [15:0] ata_data
);

   localparam logic [3:0] SETUP_LD  = (T_SETUP  == 0) ? 4'd0 : 4'(T_SETUP  - 1);
   localparam logic [3:0] STROBE_LD = (T_STROBE == 0) ? 4'd0 : 4'(T_STROBE - 1);
   localparam logic [3:0] HOLD_LD   = (T_HOLD   == 0) ? 4'd0 : 4'(T_HOLD   - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        grant_q, grant_d;
   logic        we_q, we_d;
   logic        cs1_q, cs1_d;
   logic [2:0]  adr_q, adr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        busy_q, busy_d;
   logic [1:0]  cs_n_q, cs_n_d;
   logic        iord_n_q, iord_n_d;
   logic        iowr_n_q, iowr_n_d;
   logic        oe_q, oe_d;
   logic        win;
   logic        active;
`ifdef ATA_ARB_ROUND_ROBIN_EN
   logic        last_q, last_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      we_d    = we_q;
      cs1_d   = cs1_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef ATA_ARB_ROUND_ROBIN_EN
      last_d  = last_q;
      win     = (req0 && req1) ? ~last_q : ~req0;
`else
      win     = ~req0;
`endif

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d = S_SETUP;
               cnt_d   = SETUP_LD;
               grant_d = win;
               we_d    = win ? we1     : we0;
               cs1_d   = win ? cs1sel1 : cs1sel0;
               adr_d   = win ? adr1    : adr0;
               wdata_d = win ? wdata1  : wdata0;
`ifdef ATA_ARB_ROUND_ROBIN_EN
               last_d  = win;
`endif
            end
         end
         S_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = S_STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
               // Sample the pins while IORD is still low on its last cycle.
               if (!we_q) rdata_d = ata_data;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q == 4'd0) state_d = S_DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Pin outputs are registered from the next state so they line up with the state they belong to.
      active   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      cs_n_d   = active ? (cs1_d ? 2'b01 : 2'b10) : 2'b11;
      iord_n_d = !((state_d == S_STROBE) && !we_d);
      iowr_n_d = !((state_d == S_STROBE) && we_d);
      oe_d     = active && we_d;
      ack0_d   = (state_d == S_DONE) && !grant_d;
      ack1_d   = (state_d == S_DONE) && grant_d;
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         grant_q  <= 1'b0;
         we_q     <= 1'b0;
         cs1_q    <= 1'b0;
         adr_q    <= 3'd0;
         wdata_q  <= 16'd0;
         rdata_q  <= 16'd0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         busy_q   <= 1'b0;
         cs_n_q   <= 2'b11;
         iord_n_q <= 1'b1;
         iowr_n_q <= 1'b1;
         oe_q     <= 1'b0;
`ifdef ATA_ARB_ROUND_ROBIN_EN
         last_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         we_q     <= we_d;
         cs1_q    <= cs1_d;
         adr_q    <= adr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         busy_q   <= busy_d;
         cs_n_q   <= cs_n_d;
         iord_n_q <= iord_n_d;
         iowr_n_q <= iowr_n_d;
         oe_q     <= oe_d;
`ifdef ATA_ARB_ROUND_ROBIN_EN
         last_q   <= last_d;
`endif
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign ata_cs_n   = cs_n_q;
   assign ata_adr    = adr_q;
   assign ata_iord_n = iord_n_q;
   assign ata_iowr_n = iowr_n_q;
   assign ata_data   = oe_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_ata_pio_arbiter.sv
// Bench for ata_pio_arbiter: table vectors, arbitration/reset sequences, random episodes
// against a timing/arbitration model, and a long-timing second instance.
module tb_ata_pio_arbiter;

   localparam int TS  = 1;
   localparam int TST = 2;
   localparam int TH  = 1;
   localparam int TOT = TS + TST + TH;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1, cs1sel0, cs1sel1;
   logic [2:0]  adr0, adr1;
   logic [15:0] wdata0, wdata1;
   logic        ack0, ack1, busy, ata_iord_n, ata_iowr_n;
   logic [15:0] rdata;
   logic [1:0]  ata_cs_n;
   logic [2:0]  ata_adr;
   wire  [15:0] ata_data;
   logic [15:0] dev_val;

   logic        req0_b;
   logic        ack0_b, ack1_b, busy_b, ata_iord_n_b, ata_iowr_n_b;
   logic [15:0] rdata_b;
   logic [1:0]  ata_cs_n_b;
   logic [2:0]  ata_adr_b;
   wire  [15:0] ata_data_b;

   int n_chk = 0;
   int n_err = 0;
   int model_last;
   logic [15:0] model_rdata;

   always #5 clk = ~clk;

   // Device model: drives the bus only while the read strobe is low.
   assign ata_data   = (ata_iord_n == 1'b0)   ? dev_val  : 16'hzzzz;
   assign ata_data_b = (ata_iord_n_b == 1'b0) ? 16'h1234 : 16'hzzzz;

   ata_pio_arbiter #(.T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH)) u_dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .cs1sel0(cs1sel0), .cs1sel1(cs1sel1), .adr0(adr0), .adr1(adr1),
      .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
      .busy(busy), .ata_cs_n(ata_cs_n), .ata_adr(ata_adr), .ata_iord_n(ata_iord_n),
      .ata_iowr_n(ata_iowr_n), .ata_data(ata_data));

   ata_pio_arbiter #(.T_SETUP(3), .T_STROBE(4), .T_HOLD(2)) u_dut_b (
      .clk(clk), .reset(reset), .req0(req0_b), .req1(1'b0), .we0(1'b0), .we1(1'b0),
      .cs1sel0(1'b0), .cs1sel1(1'b0), .adr0(3'd4), .adr1(3'd0),
      .wdata0(16'h0000), .wdata1(16'h0000), .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b),
      .busy(busy_b), .ata_cs_n(ata_cs_n_b), .ata_adr(ata_adr_b), .ata_iord_n(ata_iord_n_b),
      .ata_iowr_n(ata_iowr_n_b), .ata_data(ata_data_b));

   typedef struct {
      int          id;
      logic        we;
      logic        cs1;
      logic [2:0]  adr;
      logic [15:0] wd;
      logic [15:0] dv;
      logic [1:0]  exp_cs;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vt[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Released bus must not carry the write data the DUT holds.
   task automatic chk_free(input string nm, input logic [15:0] act, input logic [15:0] wd);
      n_chk++;
      if (act === wd) begin
         n_err++;
         $display("FAIL %s: bus shows %h, expected released (not %h)", nm, act, wd);
      end
   endtask

   task automatic set_req(input int id, input logic we, input logic cs1,
                          input logic [2:0] adr, input logic [15:0] wd);
      if (id == 0) begin
         we0 = we; cs1sel0 = cs1; adr0 = adr; wdata0 = wd; req0 = 1'b1;
      end else begin
         we1 = we; cs1sel1 = cs1; adr1 = adr; wdata1 = wd; req1 = 1'b1;
      end
   endtask

   // Called at the negedge of the IDLE cycle in which the winner is sampled; ends at the next IDLE negedge.
   task automatic watch(input int id, input logic we, input logic [1:0] exp_cs, input logic [2:0] adr,
                        input logic [15:0] wd, input logic [15:0] dv, input logic [15:0] exp_rd,
                        input bit drop, input string nm);
      dev_val    = dv;
      model_last = id;
      for (int k = 1; k <= TOT + 2; k++) begin
         bit act, strobe, done;
         @(negedge clk);
         act    = (k <= TOT);
         strobe = (k > TS) && (k <= TS + TST);
         done   = (k == TOT + 1);
         chk($sformatf("%s k%0d cs_n", nm, k), {30'd0, ata_cs_n}, {30'd0, act ? exp_cs : 2'b11});
         if (act) chk($sformatf("%s k%0d adr", nm, k), {29'd0, ata_adr}, {29'd0, adr});
         chk($sformatf("%s k%0d iord_n", nm, k), {31'd0, ata_iord_n}, {31'd0, !(strobe && !we)});
         chk($sformatf("%s k%0d iowr_n", nm, k), {31'd0, ata_iowr_n}, {31'd0, !(strobe && we)});
         chk($sformatf("%s k%0d busy", nm, k), {31'd0, busy}, {31'd0, k <= TOT + 1});
         chk($sformatf("%s k%0d ack0", nm, k), {31'd0, ack0}, {31'd0, done && (id == 0)});
         chk($sformatf("%s k%0d ack1", nm, k), {31'd0, ack1}, {31'd0, done && (id == 1)});
         if (we && act)         chk($sformatf("%s k%0d data", nm, k), {16'd0, ata_data}, {16'd0, wd});
         else if (!we && strobe) chk($sformatf("%s k%0d rd bus", nm, k), {16'd0, ata_data}, {16'd0, dv});
         else                   chk_free($sformatf("%s k%0d bus", nm, k), ata_data, wd);
         if (done) begin
            chk($sformatf("%s rdata", nm), {16'd0, rdata}, {16'd0, exp_rd});
            model_rdata = exp_rd;
            if (drop) begin
               if (id == 0) req0 = 1'b0; else req1 = 1'b0;
            end
         end
      end
   endtask

   initial begin
      int w, pend;
      bit dropit;
      logic        r_we[2], r_cs[2];
      logic [2:0]  r_adr[2];
      logic [15:0] r_wd[2], r_dv[2];
      int ack_cyc, iord_cnt;

      vt[0] = '{0, 1'b0, 1'b0, 3'd7, 16'hBEEF, 16'h0050, 2'b10, 16'h0050};
      vt[1] = '{1, 1'b1, 1'b0, 3'd6, 16'h00E0, 16'h0000, 2'b10, 16'h0050};
      vt[2] = '{1, 1'b0, 1'b1, 3'd6, 16'h0F0F, 16'h00D0, 2'b01, 16'h00D0};
      vt[3] = '{0, 1'b1, 1'b1, 3'd2, 16'hFFFF, 16'h0000, 2'b01, 16'h00D0};
      vt[4] = '{0, 1'b0, 1'b0, 3'd0, 16'h0001, 16'hFFFF, 2'b10, 16'hFFFF};

      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      cs1sel0 = 1'b0; cs1sel1 = 1'b0; adr0 = 3'd0; adr1 = 3'd0;
      wdata0 = 16'hA5A5; wdata1 = 16'h5A5A; dev_val = 16'h0000; req0_b = 1'b0;
      model_last = 1; model_rdata = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst cs_n", {30'd0, ata_cs_n}, 32'd3);
      chk("rst adr", {29'd0, ata_adr}, 32'd0);
      chk("rst iord_n", {31'd0, ata_iord_n}, 32'd1);
      chk("rst iowr_n", {31'd0, ata_iowr_n}, 32'd1);
      chk("rst ack0", {31'd0, ack0}, 32'd0);
      chk("rst ack1", {31'd0, ack1}, 32'd0);
      chk("rst rdata", {16'd0, rdata}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         set_req(vt[i].id, vt[i].we, vt[i].cs1, vt[i].adr, vt[i].wd);
         watch(vt[i].id, vt[i].we, vt[i].exp_cs, vt[i].adr, vt[i].wd, vt[i].dv,
               vt[i].exp_rd, 1'b1, $sformatf("vec%0d", i));
      end

      // Both requesters held high from a fresh reset.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_last = 1; model_rdata = 16'h0000;
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 3'd1, 16'h1357);
      set_req(1, 1'b1, 1'b1, 3'd5, 16'h2468);
      for (int i = 0; i < 4; i++) begin
`ifdef ATA_ARB_ROUND_ROBIN_EN
         w = i % 2;
`else
         w = (i < 3) ? 0 : 1;
`endif
         dropit = (i >= 2);
         if (w == 0) watch(0, 1'b0, 2'b10, 3'd1, 16'h1357, 16'h00A0 + 16'(i), 16'h00A0 + 16'(i),
                           dropit, $sformatf("tie%0d g0", i));
         else        watch(1, 1'b1, 2'b01, 3'd5, 16'h2468, 16'h0000, model_rdata,
                           dropit, $sformatf("tie%0d g1", i));
      end

      // Reset in the second strobe cycle of a write.
      set_req(0, 1'b1, 1'b0, 3'd3, 16'hC3C3);
      repeat (TS + 2) @(negedge clk);
      chk("mid iowr_n low", {31'd0, ata_iowr_n}, 32'd0);
      reset = 1'b1;
      req0  = 1'b0;
      @(negedge clk);
      chk("mid iowr_n", {31'd0, ata_iowr_n}, 32'd1);
      chk("mid cs_n", {30'd0, ata_cs_n}, 32'd3);
      chk("mid ack0", {31'd0, ack0}, 32'd0);
      chk("mid busy", {31'd0, busy}, 32'd0);
      chk_free("mid bus", ata_data, 16'hC3C3);
      reset = 1'b0;
      model_last = 1; model_rdata = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("post rst%0d ack0", i), {31'd0, ack0}, 32'd0);
         chk($sformatf("post rst%0d busy", i), {31'd0, busy}, 32'd0);
      end
      set_req(0, 1'b0, 1'b0, 3'd4, 16'h7777);
      watch(0, 1'b0, 2'b10, 3'd4, 16'h7777, 16'h4242, 16'h4242, 1'b1, "fresh");

      // Random episodes: one or both requesters, model picks the service order.
      for (int e = 0; e < 25; e++) begin
         pend = $urandom_range(1, 3);
         for (int id = 0; id < 2; id++) begin
            r_we[id]  = 1'($urandom_range(0, 1));
            r_cs[id]  = 1'($urandom_range(0, 1));
            r_adr[id] = 3'($urandom_range(0, 7));
            r_wd[id]  = 16'($urandom_range(1, 16'hFFFE));
            r_dv[id]  = 16'($urandom_range(0, 16'hFFFF));
            if (pend[id]) set_req(id, r_we[id], r_cs[id], r_adr[id], r_wd[id]);
         end
         while (pend != 0) begin
`ifdef ATA_ARB_ROUND_ROBIN_EN
            w = (pend == 3) ? 1 - model_last : ((pend == 2) ? 1 : 0);
`else
            w = (pend == 2) ? 1 : 0;
`endif
            watch(w, r_we[w], r_cs[w] ? 2'b01 : 2'b10, r_adr[w], r_wd[w], r_dv[w],
                  r_we[w] ? model_rdata : r_dv[w], 1'b1, $sformatf("rnd%0d g%0d", e, w));
            pend = pend & ~(1 << w);
         end
      end

      // Long-timing instance: latency and strobe width.
      ack_cyc = 0; iord_cnt = 0;
      req0_b = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (!ata_iord_n_b) iord_cnt++;
         if (ack0_b && ack_cyc == 0) begin
            ack_cyc = c;
            req0_b  = 1'b0;
         end
      end
      chk("long ack cycle", ack_cyc, 32'd10);
      chk("long iord width", iord_cnt, 32'd4);
      chk("long rdata", {16'd0, rdata_b}, 32'h1234);
      chk("long busy idle", {31'd0, busy_b}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
